// File: rtl/filter_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : filter_rd_ctrl
// Purpose : Reads accepted 188-byte packets out of the ping-pong data RAM and
//           streams them with their match index; rejected packets are skipped.
// Revision: 1.0 - initial release
// ============================================================================
module filter_rd_ctrl #(
    parameter int PKT_LEN         = 188,
    parameter int DRAM_ADDR_WIDTH = 9,
    parameter int DRAM_RD_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       filter_eop,
    input  logic                       pid_find,
    input  logic [11:0]                pid_index,
    output logic [DRAM_ADDR_WIDTH-1:0] dram_raddr,
    input  logic [7:0]                 dram_rdata,
    output logic                       ts_out_valid,
    output logic [7:0]                 ts_out_data,
    output logic                       ts_out_sop,
    output logic                       ts_out_eop,
    output logic [11:0]                ts_out_index,
    output logic [15:0]                drop_cnt,
    output logic                       busy
);

    localparam int                 c_CNT_W = DRAM_ADDR_WIDTH - 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PKT_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_nxt_state;
    logic               r_bank_wr;
    logic [c_CNT_W-1:0] r_rd_cnt;
    logic               r_job_bank;
    logic [11:0]        r_job_index;
    logic               r_pend_full;
    logic               r_pend_bank;
    logic [11:0]        r_pend_index;
    logic [15:0]        r_drop_cnt;

    logic w_job_new;
    logic w_last;
    logic w_start;
    logic w_take_pend;
    logic w_take_new;
    logic w_pend_fill;
    logic w_drop;
    logic w_valid;
    logic w_sop;
    logic w_eop;

    logic [DRAM_RD_LATENCY-1:0] r_dly_valid;
    logic [DRAM_RD_LATENCY-1:0] r_dly_sop;
    logic [DRAM_RD_LATENCY-1:0] r_dly_eop;
    logic [11:0]                r_dly_index [DRAM_RD_LATENCY];

    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_out_sop;
    logic        r_out_eop;
    logic [11:0] r_out_index;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_job_new   = filter_eop & pid_find;
        w_last      = (r_state == ST_READ) && (r_rd_cnt == c_LAST);
        w_start     = 1'b0;
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_pend_full || w_job_new) begin
                    w_start     = 1'b1;
                    w_nxt_state = ST_READ;
                end
            end
            ST_READ: begin
                if (w_last) begin
                    if (r_pend_full || w_job_new) begin
                        w_start = 1'b1;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
        // The pending job always wins the start slot; a new job then refills it.
        w_take_pend = w_start & r_pend_full;
        w_take_new  = w_start & ~r_pend_full;
        w_pend_fill = w_job_new & ~w_take_new & (~r_pend_full | w_take_pend);
        w_drop      = w_job_new & ~w_take_new & r_pend_full & ~w_take_pend;
        w_valid     = (r_state == ST_READ);
        w_sop       = w_valid && (r_rd_cnt == '0);
        w_eop       = w_valid && (r_rd_cnt == c_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_wr    <= 1'b0;
            r_rd_cnt     <= '0;
            r_job_bank   <= 1'b0;
            r_job_index  <= '0;
            r_pend_full  <= 1'b0;
            r_pend_bank  <= 1'b0;
            r_pend_index <= '0;
            r_drop_cnt   <= '0;
        end else begin
            if (filter_eop) begin
                r_bank_wr <= ~r_bank_wr;
            end
            if (w_start) begin
                r_rd_cnt    <= '0;
                r_job_bank  <= w_take_pend ? r_pend_bank  : r_bank_wr;
                r_job_index <= w_take_pend ? r_pend_index : pid_index;
            end else if ((r_state == ST_READ) && !w_last) begin
                r_rd_cnt <= r_rd_cnt + c_ONE;
            end
            if (w_pend_fill) begin
                r_pend_full  <= 1'b1;
                r_pend_bank  <= r_bank_wr;
                r_pend_index <= pid_index;
            end else if (w_take_pend) begin
                r_pend_full <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Sideband delay line matches the RAM read latency so it lines up with rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly_valid <= '0;
            r_dly_sop   <= '0;
            r_dly_eop   <= '0;
            for (int i = 0; i < DRAM_RD_LATENCY; i++) begin
                r_dly_index[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_index <= '0;
        end else begin
            r_dly_valid[0] <= w_valid;
            r_dly_sop[0]   <= w_sop;
            r_dly_eop[0]   <= w_eop;
            r_dly_index[0] <= r_job_index;
            for (int i = 1; i < DRAM_RD_LATENCY; i++) begin
                r_dly_valid[i] <= r_dly_valid[i-1];
                r_dly_sop[i]   <= r_dly_sop[i-1];
                r_dly_eop[i]   <= r_dly_eop[i-1];
                r_dly_index[i] <= r_dly_index[i-1];
            end
            r_out_valid <= r_dly_valid[DRAM_RD_LATENCY-1];
            r_out_data  <= dram_rdata;
            r_out_sop   <= r_dly_sop[DRAM_RD_LATENCY-1];
            r_out_eop   <= r_dly_eop[DRAM_RD_LATENCY-1];
            r_out_index <= r_dly_index[DRAM_RD_LATENCY-1];
        end
    end

    assign dram_raddr   = {r_job_bank, r_rd_cnt};
    assign ts_out_valid = r_out_valid;
    assign ts_out_data  = r_out_data;
    assign ts_out_sop   = r_out_sop;
    assign ts_out_eop   = r_out_eop;
    assign ts_out_index = r_out_index;
    assign drop_cnt     = r_drop_cnt;
    assign busy         = (r_state != ST_IDLE) | r_pend_full;

endmodule
`default_nettype wire

// File: tb/tb_filter_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_filter_rd_ctrl
// Purpose : Directed self-checking bench for filter_rd_ctrl with a 2-cycle RAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_filter_rd_ctrl;

    localparam int PKT_LEN = 188;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        filter_eop = 1'b0;
    logic        pid_find   = 1'b0;
    logic [11:0] pid_index  = '0;
    logic [8:0]  dram_raddr;
    logic [7:0]  dram_rdata;
    logic        ts_out_valid;
    logic [7:0]  ts_out_data;
    logic        ts_out_sop;
    logic        ts_out_eop;
    logic [11:0] ts_out_index;
    logic [15:0] drop_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] mem [0:511];
    logic [7:0] rd_pipe;

    typedef struct packed {
        int          cyc;
        logic [7:0]  data;
        logic        sop;
        logic        eop;
        logic [11:0] idx;
    } rec_t;

    rec_t q[$];

    filter_rd_ctrl #(.PKT_LEN(188), .DRAM_ADDR_WIDTH(9), .DRAM_RD_LATENCY(2)) dut (
        .clk(clk), .rst(rst), .filter_eop(filter_eop), .pid_find(pid_find),
        .pid_index(pid_index), .dram_raddr(dram_raddr), .dram_rdata(dram_rdata),
        .ts_out_valid(ts_out_valid), .ts_out_data(ts_out_data), .ts_out_sop(ts_out_sop),
        .ts_out_eop(ts_out_eop), .ts_out_index(ts_out_index), .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle read RAM: address registered, then data registered.
    always @(posedge clk) begin
        rd_pipe    <= mem[dram_raddr];
        dram_rdata <= rd_pipe;
    end

    always @(negedge clk) begin
        if (ts_out_valid) q.push_back('{cyc, ts_out_data, ts_out_sop, ts_out_eop, ts_out_index});
    end

    // Bank 0 holds k, bank 1 holds ~k, so the bank read is visible in the data.
    function automatic logic [7:0] exp_byte(input int bank, input int k);
        logic [7:0] b;
        b = 8'(k);
        return (bank != 0) ? ~b : b;
    endfunction

    task automatic do_reset();
        rst = 1'b1; filter_eop = 1'b0; pid_find = 1'b0; pid_index = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; filter_eop = 1'b0; pid_find = 1'b0; pid_index = '0;
        repeat (3) @(negedge clk);
        checks++; if (ts_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ts_out_valid); end
        checks++; if (ts_out_sop !== 1'b0) begin failures++; $display("FAIL reset_sop got=%b exp=0", ts_out_sop); end
        checks++; if (ts_out_eop !== 1'b0) begin failures++; $display("FAIL reset_eop got=%b exp=0", ts_out_eop); end
        checks++; if (ts_out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", ts_out_data); end
        checks++; if (ts_out_index !== 12'h000) begin failures++; $display("FAIL reset_index got=%h exp=000", ts_out_index); end
        checks++; if (drop_cnt !== 16'h0000) begin failures++; $display("FAIL reset_drop_cnt got=%h exp=0000", drop_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dram_raddr !== 9'h000) begin failures++; $display("FAIL reset_raddr got=%h exp=000", dram_raddr); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
        checks++; if (ts_out_valid !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", ts_out_valid); end
        q.delete();
    endtask

    task automatic test_single_accept();
        int   t0;
        rec_t e;
        do_reset();
        t0 = cyc;
        filter_eop = 1'b1; pid_find = 1'b1; pid_index = 12'h0A5;
        @(negedge clk);
        filter_eop = 1'b0; pid_find = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        for (int i = 0; i < PKT_LEN; i++) begin
            checks++;
            if (dram_raddr !== 9'(i)) begin failures++; $display("FAIL single_raddr[%0d] got=%h exp=%h", i, dram_raddr, 9'(i)); end
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (q.size() != PKT_LEN) begin failures++; $display("FAIL single_count got=%0d exp=%0d", q.size(), PKT_LEN); end
        for (int k = 0; k < q.size() && k < PKT_LEN; k++) begin
            e = '{t0 + 4 + k, exp_byte(0, k), (k == 0), (k == PKT_LEN - 1), 12'h0A5};
            checks++;
            if (q[k] !== e) begin
                failures++;
                $display("FAIL single_byte[%0d] got cyc=%0d data=%h sop=%b eop=%b idx=%h exp cyc=%0d data=%h sop=%b eop=%b idx=%h",
                         k, q[k].cyc - t0, q[k].data, q[k].sop, q[k].eop, q[k].idx, e.cyc - t0, e.data, e.sop, e.eop, e.idx);
            end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_reject_then_accept();
        int   t0;
        int   t1;
        rec_t e;
        do_reset();
        t0 = cyc;
        filter_eop = 1'b1; pid_find = 1'b0; pid_index = 12'h7FF;
        @(negedge clk);
        filter_eop = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reject_busy got=%b exp=0", busy); end
        repeat (187) @(negedge clk);
        t1 = cyc;
        filter_eop = 1'b1; pid_find = 1'b1; pid_index = 12'h123;
        @(negedge clk);
        filter_eop = 1'b0; pid_find = 1'b0;
        for (int i = 0; i < PKT_LEN; i++) begin
            checks++;
            if (dram_raddr !== 9'(256 + i)) begin failures++; $display("FAIL reject_raddr[%0d] got=%h exp=%h", i, dram_raddr, 9'(256 + i)); end
            @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++; if (q.size() != PKT_LEN) begin failures++; $display("FAIL reject_count got=%0d exp=%0d", q.size(), PKT_LEN); end
        for (int k = 0; k < q.size() && k < PKT_LEN; k++) begin
            e = '{t1 + 4 + k, exp_byte(1, k), (k == 0), (k == PKT_LEN - 1), 12'h123};
            checks++;
            if (q[k] !== e) begin
                failures++;
                $display("FAIL reject_byte[%0d] got cyc=%0d data=%h sop=%b eop=%b idx=%h exp cyc=%0d data=%h sop=%b eop=%b idx=%h",
                         k, q[k].cyc - t0, q[k].data, q[k].sop, q[k].eop, q[k].idx, e.cyc - t0, e.data, e.sop, e.eop, e.idx);
            end
        end
    endtask

    task automatic test_back_to_back();
        int   t0;
        int   n;
        int   k;
        rec_t e;
        do_reset();
        t0 = cyc;
        for (int c = 0; c < 8 * PKT_LEN + 30; c++) begin
            filter_eop = (c % PKT_LEN == 0) && (c < 8 * PKT_LEN);
            pid_find   = filter_eop;
            pid_index  = 12'h400 + 12'((c / PKT_LEN) * 17);
            @(negedge clk);
        end
        filter_eop = 1'b0; pid_find = 1'b0;
        checks++; if (q.size() != 8 * PKT_LEN) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", q.size(), 8 * PKT_LEN); end
        for (int j = 0; j < q.size() && j < 8 * PKT_LEN; j++) begin
            n = j / PKT_LEN;
            k = j % PKT_LEN;
            e = '{t0 + 4 + j, exp_byte(n % 2, k), (k == 0), (k == PKT_LEN - 1), 12'h400 + 12'(n * 17)};
            checks++;
            if (q[j] !== e) begin
                failures++;
                $display("FAIL b2b_byte[%0d] got cyc=%0d data=%h sop=%b eop=%b idx=%h exp cyc=%0d data=%h sop=%b eop=%b idx=%h",
                         j, q[j].cyc - t0, q[j].data, q[j].sop, q[j].eop, q[j].idx, e.cyc - t0, e.data, e.sop, e.eop, e.idx);
            end
        end
        checks++; if (drop_cnt !== 16'd0) begin failures++; $display("FAIL b2b_drop_cnt got=%0d exp=0", drop_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_overflow();
        int   t0;
        int   n;
        int   k;
        rec_t e;
        logic [11:0] idx_tab [3];
        idx_tab[0] = 12'h011; idx_tab[1] = 12'h022; idx_tab[2] = 12'h033;
        do_reset();
        t0 = cyc;
        for (int s = 0; s < 3; s++) begin
            filter_eop = 1'b1; pid_find = 1'b1; pid_index = idx_tab[s];
            @(negedge clk);
        end
        filter_eop = 1'b0; pid_find = 1'b0;
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL ovf_drop_early got=%0d exp=1", drop_cnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovf_busy got=%b exp=1", busy); end
        repeat (400) @(negedge clk);
        checks++; if (q.size() != 2 * PKT_LEN) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", q.size(), 2 * PKT_LEN); end
        for (int j = 0; j < q.size() && j < 2 * PKT_LEN; j++) begin
            n = j / PKT_LEN;
            k = j % PKT_LEN;
            e = '{t0 + 4 + j, exp_byte(n, k), (k == 0), (k == PKT_LEN - 1), idx_tab[n]};
            checks++;
            if (q[j] !== e) begin
                failures++;
                $display("FAIL ovf_byte[%0d] got cyc=%0d data=%h sop=%b eop=%b idx=%h exp cyc=%0d data=%h sop=%b eop=%b idx=%h",
                         j, q[j].cyc - t0, q[j].data, q[j].sop, q[j].eop, q[j].idx, e.cyc - t0, e.data, e.sop, e.eop, e.idx);
            end
        end
        checks++; if (drop_cnt !== 16'd1) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_packet();
        int t0;
        int t1;
        do_reset();
        t0 = cyc;
        filter_eop = 1'b1; pid_find = 1'b1; pid_index = 12'h0C3;
        @(negedge clk);
        while (cyc < t0 + 104) begin
            filter_eop = (cyc == t0 + 10) || (cyc == t0 + 20);
            pid_find   = (cyc == t0 + 10);
            pid_index  = 12'h0D4;
            @(negedge clk);
        end
        filter_eop = 1'b0; pid_find = 1'b0;
        checks++; if (ts_out_valid !== 1'b1 || ts_out_data !== 8'd100) begin
            failures++; $display("FAIL mid_byte100 got valid=%b data=%0d exp valid=1 data=100", ts_out_valid, ts_out_data); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ts_out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", ts_out_valid); end
        checks++; if (ts_out_sop !== 1'b0 || ts_out_eop !== 1'b0) begin
            failures++; $display("FAIL mid_sop_eop got=%b%b exp=00", ts_out_sop, ts_out_eop); end
        checks++; if (ts_out_data !== 8'h00) begin failures++; $display("FAIL mid_data got=%h exp=00", ts_out_data); end
        checks++; if (ts_out_index !== 12'h000) begin failures++; $display("FAIL mid_index got=%h exp=000", ts_out_index); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (dram_raddr !== 9'h000) begin failures++; $display("FAIL mid_raddr got=%h exp=000", dram_raddr); end
        checks++; if (q.size() != 101) begin failures++; $display("FAIL mid_count got=%0d exp=101", q.size()); end
        checks++; if (q.size() > 0 && q[q.size()-1].eop !== 1'b0) begin failures++; $display("FAIL mid_no_eop got=1 exp=0"); end
        rst = 1'b0;
        q.delete();
        repeat (200) @(negedge clk);
        checks++; if (q.size() != 0) begin failures++; $display("FAIL mid_jobs_discarded got=%0d exp=0", q.size()); end
        t1 = cyc;
        filter_eop = 1'b1; pid_find = 1'b1; pid_index = 12'h0E7;
        @(negedge clk);
        filter_eop = 1'b0; pid_find = 1'b0;
        checks++; if (dram_raddr !== 9'h000) begin failures++; $display("FAIL post_raddr got=%h exp=000", dram_raddr); end
        repeat (2) @(negedge clk);
        checks++; if (ts_out_valid !== 1'b0) begin failures++; $display("FAIL post_early_valid got=%b exp=0", ts_out_valid); end
        @(negedge clk);
        checks++; if (cyc != t1 + 4 || ts_out_valid !== 1'b1 || ts_out_sop !== 1'b1 || ts_out_data !== 8'h00 || ts_out_index !== 12'h0E7) begin
            failures++; $display("FAIL post_sop got valid=%b sop=%b data=%h idx=%h exp valid=1 sop=1 data=00 idx=0e7",
                                 ts_out_valid, ts_out_sop, ts_out_data, ts_out_index); end
        repeat (200) @(negedge clk);
        checks++; if (q.size() != PKT_LEN) begin failures++; $display("FAIL post_count got=%0d exp=%0d", q.size(), PKT_LEN); end
        checks++; if (q.size() > 0 && (q[q.size()-1].eop !== 1'b1 || q[q.size()-1].data !== 8'd187)) begin
            failures++; $display("FAIL post_last got eop=%b data=%0d exp eop=1 data=187", q[q.size()-1].eop, q[q.size()-1].data); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'(i);
            mem[256 + i] = ~8'(i);
        end
        test_reset();
        test_single_accept();
        test_reject_then_accept();
        test_back_to_back();
        test_overflow();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
